// File: rtl/cp0_timer.sv
// CP0 with SR/Cause/EPC/PrID and an optional Count/Compare timer.
// Timer logic is built only when CP0_TIMER_EN is defined.
module cp0_timer #(
  parameter int          HWINT_W   = 6,
  parameter logic [31:0] PRID      = 32'h66666666,
  parameter int          COUNT_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         a,
  input  logic [31:0]        din,
  input  logic               we,
  input  logic [29:0]        pc_int,
  input  logic [4:0]         exc_code,
  input  logic [HWINT_W-1:0] hwint,
  input  logic               bd,
  input  logic               eret,
  output logic [31:0]        dout,
  output logic [31:0]        epc,
  output logic               int_req
);

  if (HWINT_W < 1 || HWINT_W > 6) begin : g_bad_hwint
    $error("HWINT_W must be 1..6");
  end
  if (COUNT_DIV < 1 || COUNT_DIV > 256) begin : g_bad_div
    $error("COUNT_DIV must be 1..256");
  end

  logic [HWINT_W-1:0] im_q, im_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [HWINT_W-1:0] irq_vec;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [4:0]         exc_q, exc_d;
  logic [31:0]        epc_q, epc_d;
  logic               ti;
  logic               in_exc;
  logic               ext_int;
  logic               wr;
  logic [31:0]        sr;
  logic [31:0]        cause;
  logic [31:0]        cnt_rd;
  logic [31:0]        cmp_rd;

  // mtc0 only takes effect when no entry or eret claims the cycle
  assign wr = we & ~int_req & ~eret;

`ifdef CP0_TIMER_EN
  localparam logic [7:0] DIV_M1 = 8'(COUNT_DIV - 1);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] count_inc;
  logic [7:0]  presc_q, presc_d;
  logic        ti_q, ti_d;
  logic        tick;

  assign count_inc = count_q + 32'd1;
  assign tick      = (presc_q == DIV_M1);

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    presc_d   = tick ? 8'd0 : presc_q + 8'd1;
    if (wr && a == 5'd9) begin
      count_d = din;
      presc_d = 8'd0;
    end else if (tick) begin
      count_d = count_inc;
      if (count_inc == compare_q)
        ti_d = 1'b1;
    end
    if (wr && a == 5'd11) begin
      compare_d = din;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      compare_q <= '0;
      presc_q   <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      presc_q   <= presc_d;
      ti_q      <= ti_d;
    end
  end

  assign ti     = ti_q;
  assign cnt_rd = count_q;
  assign cmp_rd = compare_q;
`else
  assign ti     = 1'b0;
  assign cnt_rd = '0;
  assign cmp_rd = '0;
`endif

  always_comb begin
    irq_vec            = hwint;
    irq_vec[HWINT_W-1] = hwint[HWINT_W-1] | ti;
  end

  assign in_exc  = (exc_code != 5'd0) & ~exl_q;
  assign ext_int = (|(im_q & irq_vec)) & ie_q & ~exl_q;
  assign int_req = in_exc | ext_int;

  always_comb begin
    sr                   = '0;
    sr[10 +: HWINT_W]    = im_q;
    sr[1]                = exl_q;
    sr[0]                = ie_q;
    cause                = '0;
    cause[31]            = bd_q;
    cause[30]            = ti;
    cause[10 +: HWINT_W] = ip_q;
    cause[6:2]           = exc_q;
  end

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = irq_vec;
    if (int_req) begin
      exl_d = 1'b1;
      bd_d  = bd;
      exc_d = ext_int ? 5'd0 : exc_code;
      epc_d = {(bd ? pc_int - 30'd1 : pc_int), 2'b00};
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (wr) begin
      unique case (1'b1)
        a == 5'd12: begin
          im_d  = din[10 +: HWINT_W];
          exl_d = din[1];
          ie_d  = din[0];
        end
        a == 5'd14: epc_d = {din[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    unique case (a)
      5'd9:    dout = cnt_rd;
      5'd11:   dout = cmp_rd;
      5'd12:   dout = sr;
      5'd13:   dout = cause;
      5'd14:   dout = epc_q;
      5'd15:   dout = PRID;
      default: dout = '0;
    endcase
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_cp0_timer.sv
// Bench for cp0_timer: vector table, hand-written corner sequences
// and random stimulus against a behavioural model.
module tb_cp0_timer;

  localparam int DIV = 2;
`ifdef CP0_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a;
  logic [31:0] din;
  logic        we;
  logic [29:0] pc_int;
  logic [4:0]  exc_code;
  logic [5:0]  hwint;
  logic        bd;
  logic        eret;
  logic [31:0] dout;
  logic [31:0] epc;
  logic        int_req;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  cp0_timer #(
    .HWINT_W  (6),
    .PRID     (32'h66666666),
    .COUNT_DIV(DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .din     (din),
    .we      (we),
    .pc_int  (pc_int),
    .exc_code(exc_code),
    .hwint   (hwint),
    .bd      (bd),
    .eret    (eret),
    .dout    (dout),
    .epc     (epc),
    .int_req (int_req)
  );

  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_cnt, m_cmp;
  int          m_pre;

  task automatic m_clear();
    m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0;
    m_bd = 0; m_ti = 0; m_exc = 0; m_epc = 0;
    m_cnt = 0; m_cmp = 0; m_pre = 0;
  endtask

  function automatic logic [5:0] m_irq();
    return hwint | {m_ti, 5'b0};
  endfunction

  function automatic logic m_ext();
    return ((m_im & m_irq()) != 0) && m_ie && !m_exl;
  endfunction

  function automatic logic m_intr();
    return ((exc_code != 0) && !m_exl) || m_ext();
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    case (idx)
      5'd9:    return TMR ? m_cnt : 32'd0;
      5'd11:   return TMR ? m_cmp : 32'd0;
      5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
      5'd13:   return {m_bd, m_ti, 14'b0, m_ip, 3'b0, m_exc, 2'b0};
      5'd14:   return m_epc;
      5'd15:   return 32'h66666666;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic m_update();
    logic       ir, ext, w;
    logic [5:0] irq;
    ir  = m_intr();
    ext = m_ext();
    irq = m_irq();
    w   = we && !ir && !eret;
    if (TMR) begin
      if (w && a == 5'd9) begin
        m_cnt = din;
        m_pre = 0;
      end else begin
        m_pre = m_pre + 1;
        if (m_pre == DIV) begin
          m_pre = 0;
          m_cnt = m_cnt + 1;
          if (m_cnt == m_cmp) m_ti = 1;
        end
      end
      if (w && a == 5'd11) begin
        m_cmp = din;
        m_ti  = 0;
      end
    end
    if (ir) begin
      m_exl = 1;
      m_bd  = bd;
      m_exc = ext ? 5'd0 : exc_code;
      m_epc = {2'b00, pc_int} * 4 - (bd ? 32'd4 : 32'd0);
    end else if (eret) begin
      m_exl = 0;
    end else if (w) begin
      if (a == 5'd12) begin
        m_im  = din[15:10];
        m_exl = din[1];
        m_ie  = din[0];
      end else if (a == 5'd14) begin
        m_epc = din & 32'hFFFF_FFFC;
      end
    end
    m_ip = irq;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] ia, input logic [31:0] id,
                     input logic iw, input logic [4:0] ix,
                     input logic [5:0] ih, input logic ib,
                     input logic ier, input logic [29:0] ipc);
    a = ia; din = id; we = iw; exc_code = ix;
    hwint = ih; bd = ib; eret = ier; pc_int = ipc;
  endtask

  task automatic idle(input logic [4:0] ia);
    drv(ia, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] idx, input logic [31:0] exp,
                    input string nm);
    a = idx;
    #1;
    chk(nm, dout, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(0);
    m_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] din;
    logic        we;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        bd;
    logic        eret;
    logic [29:0] pc;
    logic [31:0] exp;
    logic        expint;
  } vec_t;

  vec_t vq[$];

  initial begin
    logic [4:0] asel [8];
    asel = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};

    reset = 1'b0;
    idle(12);
    m_clear();
    #1;
    chk("rst_int", {31'b0, int_req}, 0);
    chk("rst_epc", epc, 0);
    rd(9, 0, "rst_count");
    rd(11, 0, "rst_compare");
    rd(12, 0, "rst_sr");
    rd(13, 0, "rst_cause");
    rd(15, 32'h66666666, "rst_prid");
    @(posedge clk);
    #1;
    reset = 1'b1;

    vq.push_back('{12, 0,      1, 0,  0, 0, 0, 0,     32'h0,        0});
    vq.push_back('{13, 0,      0, 4,  0, 1, 0, 'h400, 32'h0,        1});
    vq.push_back('{14, 0,      0, 0,  0, 0, 0, 0,     32'h0000_0FFC, 0});
    vq.push_back('{13, 0,      0, 0,  0, 0, 0, 0,     32'h8000_0010, 0});
    vq.push_back('{12, 0,      0, 0,  0, 0, 0, 0,     32'h2,        0});
    vq.push_back('{12, 'h401,  1, 0,  0, 0, 1, 0,     32'h2,        0});
    vq.push_back('{12, 0,      0, 0,  0, 0, 0, 0,     32'h0,        0});
    vq.push_back('{12, 'h401,  1, 0,  0, 0, 0, 0,     32'h0,        0});
    vq.push_back('{12, 0,      0, 12, 1, 0, 0, 0,     32'h401,      1});
    vq.push_back('{13, 0,      0, 0,  0, 0, 0, 0,     32'h400,      0});
    vq.push_back('{13, 0,      0, 0,  0, 0, 0, 0,     32'h0,        0});
    vq.push_back('{15, 0,      0, 0,  0, 0, 0, 0,     32'h6666_6666, 0});
    vq.push_back('{3,  0,      0, 0,  0, 0, 0, 0,     32'h0,        0});
    vq.push_back('{12, 0,      0, 0,  0, 0, 0, 0,     32'h403,      0});

    foreach (vq[i]) begin
      drv(vq[i].a, vq[i].din, vq[i].we, vq[i].exc,
          vq[i].hw, vq[i].bd, vq[i].eret, vq[i].pc);
      #1;
      chk($sformatf("vec%0d_dout", i), dout, vq[i].exp);
      chk($sformatf("vec%0d_int", i), {31'b0, int_req},
          {31'b0, vq[i].expint});
      tick();
    end

    drv(14, 32'h1234, 1, 0, 0, 0, 0, 0);
    tick();
    idle(12);
    chk("pre_rst_epc", epc, 32'h1234);
    rd(12, 32'h403, "pre_rst_sr");
    reset = 1'b0;
    #1;
    chk("mid_rst_epc", epc, 0);
    chk("mid_rst_int", {31'b0, int_req}, 0);
    rd(12, 0, "mid_rst_sr");
    rd(14, 0, "mid_rst_epcreg");
    rd(13, 0, "mid_rst_cause");
    rd(9, 0, "mid_rst_count");
    m_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef CP0_TIMER_EN
    drv(11, 10, 1, 0, 0, 0, 0, 0);
    tick();
    drv(9, 0, 1, 0, 0, 0, 0, 0);
    tick();
    drv(12, 32'h8001, 1, 0, 0, 0, 0, 0);
    tick();
    idle(9);
    repeat (18) tick();
    rd(9, 9, "tmr_cnt9");
    chk("tmr_int_before", {31'b0, int_req}, 0);
    tick();
    rd(9, 10, "tmr_cnt10");
    chk("tmr_int", {31'b0, int_req}, 1);
    tick();
    rd(13, 32'h4000_8000, "tmr_cause");
    rd(12, 32'h8003, "tmr_sr");
    drv(11, 100, 1, 0, 0, 0, 0, 0);
    tick();
    idle(13);
    rd(13, 32'h0000_8000, "tmr_ti_clr");
    tick();
    rd(13, 0, "tmr_ip_clr");
`endif

    do_reset();
    drv(13, 0, 0, 1, 0, 1, 0, 0);
    #1;
    chk("wrap_int", {31'b0, int_req}, 1);
    tick();
    idle(13);
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    rd(13, 32'h8000_0004, "wrap_cause");
`ifdef CP0_TIMER_EN
    drv(11, 0, 1, 0, 0, 0, 0, 0);
    tick();
    drv(9, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
    tick();
    idle(9);
    rd(9, 32'hFFFF_FFFF, "wrap_cnt_a");
    tick();
    rd(9, 32'hFFFF_FFFF, "wrap_cnt_b");
    tick();
    rd(9, 0, "wrap_cnt0");
    rd(13, 32'hC000_0004, "wrap_ti");
`endif

    do_reset();
    drv(12, 32'h8001, 1, 0, 0, 0, 0, 0);
    tick();
    drv(9, 5, 1, 0, 0, 0, 0, 0);
    tick();
    idle(12);
    rd(12, 32'h8001, "hw_sr");
`ifndef CP0_TIMER_EN
    rd(9, 0, "off_count");
    drv(11, 7, 1, 0, 0, 0, 0, 0);
    tick();
    idle(11);
    rd(11, 0, "off_compare");
    rd(13, 0, "off_cause");
`endif
    chk("hw5_quiet", {31'b0, int_req}, 0);
    drv(12, 0, 0, 0, 6'h20, 0, 0, 0);
    #1;
    chk("hw5_int", {31'b0, int_req}, 1);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra;
      logic [31:0] rdin;
      ra   = asel[$urandom_range(0, 7)];
      rdin = $urandom;
      if (ra == 5'd9) rdin = m_cmp - $urandom_range(0, 6);
      drv(ra, rdin, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
          ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
          1'($urandom), ($urandom_range(0, 7) == 0), 30'($urandom));
      #1;
      chk($sformatf("rnd%0d_dout", i), dout, m_read(ra));
      chk($sformatf("rnd%0d_epc", i), epc, m_epc);
      chk($sformatf("rnd%0d_int", i), {31'b0, int_req},
          {31'b0, m_intr()});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_timer.md
Name: cp0_timer

Overview:
- Parametrised next-generation system coprocessor for the pipelined MIPS core.
- Holds SR, Cause, EPC and PrID, with a configurable number of hardware interrupt lines.
- Adds a Count/Compare timer that raises an internal interrupt.
- Fixes eret/exception-entry priority with a single, defined arbitration order.
- Sits beside the M stage: takes the exception code, victim PC and branch-delay flag, and returns int_req and EPC to the PC-select logic.

Parameters:
- HWINT_W, 6, number of external interrupt lines (legal range 1..6); mapped to SR.IM/Cause.IP bits starting at bit 10.
- PRID, 32'h66666666, read-only value of PrID.
- COUNT_DIV, 1, Count increments once every COUNT_DIV clocks (legal range 1..256).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- a  in  5  CP0 register index for mfc0/mtc0.
- din  in  32  mtc0 write data.
- we  in  1  mtc0 write enable.
- pc_int  in  30  word address [31:2] of the faulting/interrupted instruction.
- exc_code  in  5  internal exception code; 0 means none.
- hwint  in  HWINT_W  level-sensitive external interrupt requests.
- bd  in  1  faulting instruction is in a branch delay slot.
- eret  in  1  eret executing this cycle.
- dout  out  32  combinational read of register a.
- epc  out  32  current EPC register.
- int_req  out  1  combinational exception/interrupt request to the pipeline.

Behaviour:
- Register map:
  - 9 Count.
  - 11 Compare.
  - 12 SR = {16'b0, IM at [9+HWINT_W:10], zeros, EXL[1], IE[0]}.
  - 13 Cause = {BD[31], TI[30], zeros, IP at [9+HWINT_W:10], zeros, ExcCode[6:2], 2'b00}.
  - 14 EPC.
  - 15 PrID.
  - Any other index reads 0.
- Reset (reset low, async):
  - IM, EXL, IE, BD, TI, IP, ExcCode, EPC, Count, Compare and prescaler all clear to 0.
  - Outputs: epc=0, int_req=0, dout per a.
- irq_vec = hwint, with TI ORed into the top line (bit HWINT_W-1).
- in_exc = (exc_code != 0) & ~EXL.
- ext_int = |(IM & irq_vec) & IE & ~EXL.
- int_req = in_exc | ext_int (combinational, zero-latency).
- Per-clock update priority, highest first:
  1. int_req (exception entry):
     - EXL<=1; BD<=bd.
     - ExcCode <= ext_int ? 0 : exc_code. External interrupt wins over a simultaneous internal exception.
     - EPC <= bd ? {pc_int-1,2'b00} : {pc_int,2'b00}. The subtraction is 30-bit and wraps modulo 2^30.
  2. eret: EXL<=0.
  3. we:
     - SR: IM, EXL, IE loaded from din.
     - EPC <= {din[31:2],2'b00}.
     - Count <= din; prescaler <= 0.
     - Compare <= din; TI <= 0.
     - Writes to Cause/PrID/unmapped indices are ignored.
  - Lower-priority actions in the same cycle are dropped entirely.
- IP <= irq_vec every clock, regardless of the above. Cause.IP therefore reads one cycle late; int_req does not.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1. Count increments when the prescaler wraps; Count wraps 32'hFFFFFFFF->0.
  - TI sets on the edge where an increment makes Count equal Compare.
  - TI stays set until a Compare write or reset.
  - A Count write in the same cycle suppresses that increment and the TI set.
- Counter and prescaler run while EXL=1.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count/Compare/TI/prescaler as above.
- Undefined:
  - No timer logic is built.
  - Indices 9/11 read 0 and writes are ignored.
  - TI reads 0; the top IP line is pure hwint.
  - COUNT_DIV is unused.

Test Plan:
- Reset: drive reset low mid-run with EXL=1, EPC=0x1234 -> all registers 0 immediately (async); int_req=0.
- Internal exception: exc_code=5'd4, pc_int=0x400 (PC 0x1000), bd=1 -> int_req=1 same cycle; next clock EPC=0x0FFC, Cause=0x80000010, EXL=1; int_req falls to 0.
- Simultaneous events:
  - SR=0x0401, hwint[0]=1, exc_code=5'd12 -> ExcCode=0 recorded.
  - eret together with we to SR while EXL=1 -> only EXL cleared, SR write dropped.
- Timer (CP0_TIMER_EN, COUNT_DIV=2):
  - Write Compare=10, Count=0, SR=0x8001 -> Count=10 after 20 clocks.
  - TI=1 and int_req=1 (HWINT_W=6).
  - Compare write clears TI.
- Wrap: Count=0xFFFFFFFF, Compare=0 -> next increment Count=0, TI=1; EPC with pc_int=0, bd=1 -> EPC=0xFFFFFFFC.
- Timer compiled out: mtc0 Count=5 then mfc0 9 -> 0; hwint[5] with IM[15]=1, IE=1 still interrupts.
